bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_to_bin_seq.sv | 140 ++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: multi-cycle packed-BCD to binary converter (reverse double dabble).
// One shift per clock with a -3 correction on every BCD nibble >= 8.
// Optional feature macro: BCD_ERR_CHECK_EN (reject inputs containing a nibble > 9).
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(DW + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DW-1:0]    bcd_q, bcd_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Right shift of the {bcd, acc} pair; bcd LSB drops into the acc MSB.
    logic [DW-1:0] bcd_sh;
    logic [DW-1:0] acc_sh;
    logic [DW-1:0] bcd_corr;
    logic          last_shift;
    logic          in_bad;

    assign bcd_sh     = {1'b0, bcd_q[DW-1:1]};
    assign acc_sh     = {bcd_q[0], acc_q[DW-1:1]};
    assign last_shift = (cnt_q == CW'(DW - 1));

    // A nibble that reads >= 8 after the shift held a "ten" in its old LSB
    // position; halving ten gives 5 = 8 - 3, so subtract 3 to restore BCD.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
            assign bcd_corr[gi*4 +: 4] = (bcd_sh[gi*4 +: 4] >= 4'd8) ?
                                         (bcd_sh[gi*4 +: 4] - 4'd3) :
                                          bcd_sh[gi*4 +: 4];
        end
    endgenerate

`ifdef BCD_ERR_CHECK_EN
    logic [DIGITS-1:0] nib_bad;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign nib_bad[gi] = (bcd_in[gi*4 +: 4] > 4'd9);
        end
    endgenerate
    assign in_bad = |nib_bad;
`else
    // No digit check: invalid digits simply run through the algorithm.
    assign in_bad = 1'b0;
`endif

    // Next-state logic for the IDLE/SHIFT controller and datapath.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (in_bad) begin
                        // Rejected input: answer immediately, never enter SHIFT.
                        bin_d  = '0;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        bcd_d   = bcd_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                bcd_d = bcd_corr;
                acc_d = acc_sh;
                cnt_d = cnt_q + CW'(1);
                if (last_shift) begin
                    // acc now holds the full binary value; upper bits are zero
                    // for valid BCD, so truncation to BIN_W is lossless.
                    bin_d   = BIN_W'(acc_sh);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous abort to the idle/cleared state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bin_out = bin_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic [13:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [13:0] exp_q[$];

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .bin_out(bin_out),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Count done pulses and check done/busy exclusivity whenever done is seen.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            checks++;
            if (busy) begin
                failures++;
                $display("FAIL done_busy_overlap: busy=%0b while done=1, required busy=0", busy);
            end
        end
    end

    function automatic logic [13:0] ref_bin(input logic [15:0] b);
        int v;
        v = int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]) + 1000 * int'(b[15:12]);
        return 14'(v);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // One conversion: push expected, wait (bounded) for done, pop and compare.
    task automatic run_conv(input logic [15:0] b, input bit scramble);
        int lat;
        int bcyc;
        logic [13:0] e;
        @(negedge clk);
        start = 1'b1;
        bcd_in = b;
        exp_q.push_back(ref_bin(b));
        lat = 0;
        bcyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bcyc++;
            if (scramble) bcd_in = 16'($urandom);
        end while (!done && lat < 40);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL conv_timeout: bcd=%h no done within %0d cycles", b, lat);
            exp_q.delete();
            return;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h0;
        $display("conv bcd=%h bin_out=%0d expected=%0d latency=%0d busy_cycles=%0d err=%0b",
                 b, bin_out, e, lat, bcyc, err);
        checks++;
        if (bin_out !== e) begin
            failures++;
            $display("FAIL conv_value: bcd=%h bin_out=%0d required %0d", b, bin_out, e);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL conv_err: bcd=%h err=%0b required 0", b, err);
        end
        checks++;
        if (lat != 17) begin
            failures++;
            $display("FAIL conv_latency: bcd=%h latency=%0d required 17", b, lat);
        end
        checks++;
        if (bcyc != 16) begin
            failures++;
            $display("FAIL conv_busy_cycles: bcd=%h busy_cycles=%0d required 16", b, bcyc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bin_out !== e) begin
            failures++;
            $display("FAIL conv_after_done: done=%0b busy=%0b bin_out=%0d required 0/0/%0d",
                     done, busy, bin_out, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bin_out !== 14'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: bin_out=%0d busy=%0b done=%0b err=%0b required all 0",
                     bin_out, busy, done, err);
        end
        $display("reset state bin_out=%0d busy=%0b done=%0b err=%0b", bin_out, busy, done, err);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_conv(16'h1234, 1'b0);
        run_conv(16'h9999, 1'b1);
        run_conv(16'h0000, 1'b0);
    endtask

    task automatic test_ignore_start();
        int lat;
        int d0;
        logic [13:0] e;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        bcd_in = 16'h0500;
        exp_q.push_back(ref_bin(16'h0500));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                start = 1'b1;
                bcd_in = 16'h0777;
            end else begin
                start = 1'b0;
            end
        end while (!done && lat < 40);
        start = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h0;
        $display("ignore bcd=0500 bin_out=%0d expected=%0d latency=%0d", bin_out, e, lat);
        checks++;
        if (!done || bin_out !== e || lat != 17) begin
            failures++;
            $display("FAIL ignore_result: done=%0b bin_out=%0d latency=%0d required 1/%0d/17",
                     done, bin_out, lat, e);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL ignore_no_second_done: done pulses=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [13:0] e;
        @(negedge clk);
        start = 1'b1;
        bcd_in = 16'h0321;
        exp_q.push_back(ref_bin(16'h0321));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h0;
        $display("b2b first bcd=0321 bin_out=%0d expected=%0d latency=%0d", bin_out, e, lat);
        checks++;
        if (!done || bin_out !== e) begin
            failures++;
            $display("FAIL b2b_first: done=%0b bin_out=%0d required 1/%0d", done, bin_out, e);
        end
        // start still high in the done cycle: the next edge must accept it.
        bcd_in = 16'h0654;
        exp_q.push_back(ref_bin(16'h0654));
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 40);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h0;
        $display("b2b second bcd=0654 bin_out=%0d expected=%0d period=%0d", bin_out, e, lat);
        checks++;
        if (!done || bin_out !== e || lat != 17) begin
            failures++;
            $display("FAIL b2b_second: done=%0b bin_out=%0d period=%0d required 1/%0d/17",
                     done, bin_out, lat, e);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_third: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        @(negedge clk);
        start = 1'b1;
        bcd_in = 16'h4321;
        exp_q.push_back(ref_bin(16'h4321));
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        $display("abort bin_out=%0d busy=%0b done=%0b err=%0b", bin_out, busy, done, err);
        checks++;
        if (bin_out !== 14'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: bin_out=%0d busy=%0b done=%0b err=%0b required all 0",
                     bin_out, busy, done, err);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL abort_no_done: done pulses=%0d required 0", done_cnt - d0);
        end
        run_conv(16'h0042, 1'b0);
    endtask

`ifdef BCD_ERR_CHECK_EN
    task automatic test_err_check();
        @(negedge clk);
        start = 1'b1;
        bcd_in = 16'h12A4;
        @(negedge clk);
        start = 1'b0;
        $display("errchk bcd=12A4 done=%0b err=%0b bin_out=%0d busy=%0b", done, err, bin_out, busy);
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || bin_out !== 14'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_detect: done=%0b err=%0b bin_out=%0d busy=%0b required 1/1/0/0",
                     done, err, bin_out, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_hold: done=%0b err=%0b busy=%0b required 0/1/0", done, err, busy);
        end
        run_conv(16'h0010, 1'b0);
    endtask
`endif

    task automatic test_sweep();
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        for (int v = 0; v < 10000; v += 13) begin
            run_conv(to_bcd(v), (v % 2) == 1);
            n++;
        end
        run_conv(to_bcd(9999), 1'b0);
        n++;
        checks++;
        if (done_cnt - d0 != n) begin
            failures++;
            $display("FAIL sweep_done_count: done pulses=%0d required %0d", done_cnt - d0, n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
`ifdef BCD_ERR_CHECK_EN
        test_err_check();
`endif
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
